// File: rtl/lane_pipe_elastic.sv
// lane_pipe_elastic: NUM_LANES x DATA_W elastic retiming pipeline, STAGES deep.
// Valid/ready handshake with a combinational ready chain, so a stalled
// output lets bubbles collapse and throughput stays at one beat per cycle.
// A synchronous flush drops everything in flight. occupancy reports the
// number of valid stages.
// Optional build macro LANE_PIPE_XFER_CNT_EN adds a saturating 16-bit
// output-transfer counter on port xfer_cnt.
module lane_pipe_elastic #(
  parameter int NUM_LANES = 2,
  parameter int DATA_W    = 8,
  parameter int STAGES    = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            flush,
  input  logic [NUM_LANES*DATA_W-1:0]     in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [NUM_LANES*DATA_W-1:0]     out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [$clog2(STAGES+1)-1:0]     occupancy
`ifdef LANE_PIPE_XFER_CNT_EN
  ,
  output logic [15:0]                     xfer_cnt
`endif
);

  localparam int W     = NUM_LANES * DATA_W;
  localparam int OCC_W = $clog2(STAGES + 1);

  logic [STAGES-1:0]         vld_q, vld_d;
  logic [STAGES-1:0][W-1:0]  dat_q, dat_d;
  logic [OCC_W-1:0]          occ_q, occ_d;
  logic [STAGES-1:0]         rdy;

  // Ready chain: a stage accepts if it is empty or anything downstream of it moves.
  // Built from the output side with a running term so no bit of rdy reads another.
  always_comb begin
    logic acc;
    acc = out_ready;
    rdy = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      acc    = ~vld_q[i] | acc;
      rdy[i] = acc;
    end
  end

  // Next-state for every stage: advance where ready, hold otherwise, flush clears valids.
  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    occ_d = '0;
    if (rdy[0]) begin
      vld_d[0] = in_valid;
      if (in_valid) begin
        dat_d[0] = in_data;
      end
    end
    for (int i = 1; i < STAGES; i++) begin
      if (rdy[i]) begin
        vld_d[i] = vld_q[i-1];
        if (vld_q[i-1]) begin
          dat_d[i] = dat_q[i-1];
        end
      end
    end
    // Data registers keep their contents on flush; only the valids drop.
    if (flush) begin
      vld_d = '0;
      dat_d = dat_q;
    end
    for (int i = 0; i < STAGES; i++) begin
      occ_d = occ_d + OCC_W'(vld_d[i]);
    end
  end

  // Stage registers and the registered occupancy count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_q <= '0;
      dat_q <= '0;
      occ_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
      occ_q <= occ_d;
    end
  end

  assign in_ready  = rdy[0] & ~flush;
  assign out_valid = vld_q[STAGES-1];
  assign out_data  = dat_q[STAGES-1];
  assign occupancy = occ_q;

`ifdef LANE_PIPE_XFER_CNT_EN
  logic [15:0] xfer_cnt_q, xfer_cnt_d;

  // Saturating count of output handshakes; flush clears and wins over an increment.
  always_comb begin
    xfer_cnt_d = xfer_cnt_q;
    if (flush) begin
      xfer_cnt_d = '0;
    end else if (out_valid && out_ready && (xfer_cnt_q != 16'hFFFF)) begin
      xfer_cnt_d = xfer_cnt_q + 16'd1;
    end
  end

  // Transfer counter register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      xfer_cnt_q <= '0;
    end else begin
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  assign xfer_cnt = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_lane_pipe_elastic.sv
// Bench for lane_pipe_elastic: directed steps followed by a randomized run,
// compared against a queue-based model of beats and their stage positions.
module tb_lane_pipe_elastic;

  localparam int NL = 2;
  localparam int DW = 8;
  localparam int S  = 2;
  localparam int W  = NL * DW;
  localparam int OW = $clog2(S + 1);

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  in_data, out_data;
  logic [OW-1:0] occupancy;
`ifdef LANE_PIPE_XFER_CNT_EN
  logic [15:0]   xfer_cnt;
`endif

  lane_pipe_elastic #(.NUM_LANES(NL), .DATA_W(DW), .STAGES(S)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .occupancy (occupancy)
`ifdef LANE_PIPE_XFER_CNT_EN
    ,
    .xfer_cnt  (xfer_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Model: beats in acceptance order, oldest first, each with its stage index.
  int           mp[$];
  logic [W-1:0] md[$];
  logic [W-1:0] m_last = '0;
  int           m_cnt  = 0;
  logic         acc_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: predict from the model, compare, take the edge, commit the model.
  task automatic cyc();
    int           np[$];
    logic [W-1:0] nd[$];
    logic [W-1:0] nlast;
    int           ncnt;
    logic         e_ov, e_ir, pop;
    #1;
    np = mp; nd = md; nlast = m_last; ncnt = m_cnt;
    e_ov = (mp.size() > 0) && (mp[0] == S - 1);
    pop  = e_ov && out_ready;
    if (pop) begin
      void'(np.pop_front());
      void'(nd.pop_front());
    end
    for (int k = 0; k < np.size(); k++) begin
      int lim;
      lim = (k == 0) ? S : np[k-1];
      if (np[k] + 1 < lim) begin
        np[k] = np[k] + 1;
        if (np[k] == S - 1) nlast = nd[k];
      end
    end
    e_ir = !flush && (np.size() == 0 || np[np.size()-1] > 0);
    acc_last = reset && in_valid && e_ir;
    if (in_valid && e_ir) begin
      np.push_back(0);
      nd.push_back(in_data);
      if (S == 1) nlast = in_data;
    end
    if (pop && ncnt < 65535) ncnt++;
    if (!reset) begin
      np.delete(); nd.delete(); nlast = '0; ncnt = 0;
    end else if (flush) begin
      np.delete(); nd.delete(); nlast = m_last; ncnt = 0;
    end
    check("in_ready",  32'(in_ready),  32'(e_ir));
    check("out_valid", 32'(out_valid), 32'(e_ov));
    check("out_data",  32'(out_data),  32'(m_last));
    check("occupancy", 32'(occupancy), 32'(mp.size()));
`ifdef LANE_PIPE_XFER_CNT_EN
    check("xfer_cnt",  32'(xfer_cnt),  32'(m_cnt));
`endif
    @(posedge clk);
    mp = np; md = nd; m_last = nlast; m_cnt = ncnt;
    @(negedge clk);
  endtask

  initial begin
    logic         pending;
    logic [W-1:0] pdata;
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);

    // Reset held for three cycles
    repeat (3) cyc();
    check("rst_out_data", 32'(out_data), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);

    // Streaming with out_ready high
    reset = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; in_data = 16'hA55A; cyc();
    in_data = 16'h0102; cyc();
    check("lat_valid", 32'(out_valid), 32'h1);
    check("lat_data", 32'(out_data), 32'hA55A);
    in_data = 16'h0304; cyc();
    check("stream_occ", 32'(occupancy), 32'h2);
    check("stream_data2", 32'(out_data), 32'h0102);
    in_valid = 1'b0; in_data = 16'hDEAD;
    repeat (3) cyc();
    check("drain_occ", 32'(occupancy), 32'h0);

    // Backpressure
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 16'h0011; cyc();
    in_data = 16'h0022; cyc();
    in_data = 16'h0033; cyc(); cyc();
    check("bp_occ", 32'(occupancy), 32'h2);
    check("bp_data", 32'(out_data), 32'h0011);
    check("bp_in_ready", 32'(in_ready), 32'h0);
    out_ready = 1'b1; cyc();
    in_valid = 1'b0; cyc();
    check("bp_last", 32'(out_data), 32'h0033);
    repeat (2) cyc();

    // Bubble collapse under a stalled output
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h00FF; cyc();
    in_valid = 1'b0;
    repeat (5) cyc();
    check("bub_occ", 32'(occupancy), 32'h1);
    check("bub_data", 32'(out_data), 32'h00FF);
    check("bub_in_ready", 32'(in_ready), 32'h1);
    in_valid = 1'b1; in_data = 16'h0AAA; cyc();
    check("bub_fill", 32'(occupancy), 32'h2);

    // Flush with a full pipe and an offered beat
    flush = 1'b1; in_data = 16'h0BBB;
    #1;
    check("flush_in_ready", 32'(in_ready), 32'h0);
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_valid", 32'(out_valid), 32'h0);
    check("flush_occ", 32'(occupancy), 32'h0);
    cyc();
    check("flush_no_accept", 32'(occupancy), 32'h0);

    // Reset in the middle of a stalled, full pipe
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 16'h0C0C; cyc();
    in_data = 16'h0D0D; cyc();
    check("mid_full", 32'(occupancy), 32'h2);
    reset = 1'b0; in_valid = 1'b0; cyc();
    reset = 1'b1;
    check("mid_rst_valid", 32'(out_valid), 32'h0);
    check("mid_rst_data", 32'(out_data), 32'h0);
    check("mid_rst_occ", 32'(occupancy), 32'h0);
`ifdef LANE_PIPE_XFER_CNT_EN
    check("mid_rst_cnt", 32'(xfer_cnt), 32'h0);
`endif

    // Randomized traffic, beats held until accepted
    pending = 1'b0; pdata = '0;
    for (int n = 0; n < 3000; n++) begin
      if (!pending && $urandom_range(3) != 0) begin
        pending = 1'b1;
        pdata   = W'($urandom);
      end
      in_valid  = pending;
      in_data   = pending ? pdata : W'($urandom);
      out_ready = (n < 1000) ? ($urandom_range(3) != 0) :
                  (n < 2000) ? 1'($urandom_range(1)) : 1'b1;
      flush     = ($urandom_range(40) == 0);
      reset     = ($urandom_range(150) != 0);
      cyc();
      if (acc_last) pending = 1'b0;
    end
    flush = 1'b0; reset = 1'b1; in_valid = 1'b0;
    repeat (3) cyc();

`ifdef LANE_PIPE_XFER_CNT_EN
    // Transfer counter saturation and flush clear
    reset = 1'b0; cyc();
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_data = 16'h5A5A;
    repeat (65540) cyc();
    check("cnt_sat", 32'(xfer_cnt), 32'hFFFF);
    in_valid = 1'b0;
    repeat (3) cyc();
    check("cnt_hold", 32'(xfer_cnt), 32'hFFFF);
    flush = 1'b1; cyc();
    flush = 1'b0;
    check("cnt_flush", 32'(xfer_cnt), 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
